// File: rtl/pmf_rs_pkg.sv
// pmf_rs_pkg: shared definitions for the add/sub reservation station and the
// downstream add/sub ALU.
//   - ALU operation encoding (ALUAdd / ALUSub)
//   - NO_TAG: tag value meaning "no producer, value is valid"
//   - default data/tag widths
//   - ALU state encodings used by the downstream ALU
package pmf_rs_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int TAG_W_DEF  = 3;
  localparam int NO_TAG     = 0;

  typedef enum logic {
    ALUAdd = 1'b0,
    ALUSub = 1'b1
  } alu_op_t;

  typedef enum logic [1:0] {
    ALU_IDLE = 2'd0,
    ALU_EXEC = 2'd1,
    ALU_DONE = 2'd2
  } alu_state_t;

endpackage

// File: rtl/pmf_rs_entry.sv
// pmf_rs_entry: one reservation-station entry.
// It holds busy/dispatched/op/Vj/Vk/Qj/Qk. It takes an issue write with a
// same-cycle CDB bypass, snoops the CDB for pending operands, and frees itself
// when its own tag (MY_TAG) is broadcast.
// Ports:
//   clk, nRST            clock, async active-low reset
//   write_en             issue this entry this cycle
//   issue_op/vj/vk/qj/qk issued instruction fields
//   cdb_valid/tag/data   common data bus
//   dispatch_set         this entry is being dispatched this cycle
//   busy, ready          registered status (ready = can be dispatched)
//   op, vj, vk           stored operation and operand values
module pmf_rs_entry
  import pmf_rs_pkg::*;
#(
  parameter int              DATA_W = DATA_W_DEF,
  parameter int              TAG_W  = TAG_W_DEF,
  parameter logic [TAG_W-1:0] MY_TAG = TAG_W'(1)
) (
  input  logic              clk,
  input  logic              nRST,
  input  logic              write_en,
  input  alu_op_t           issue_op,
  input  logic [DATA_W-1:0] issue_vj,
  input  logic [DATA_W-1:0] issue_vk,
  input  logic [TAG_W-1:0]  issue_qj,
  input  logic [TAG_W-1:0]  issue_qk,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  input  logic              dispatch_set,
  output logic              busy,
  output logic              ready,
  output alu_op_t           op,
  output logic [DATA_W-1:0] vj,
  output logic [DATA_W-1:0] vk
);

  localparam logic [TAG_W-1:0] NONE = TAG_W'(NO_TAG);

  logic             dispatched;
  logic [TAG_W-1:0] qj;
  logic [TAG_W-1:0] qk;

  logic bypass_j;
  logic bypass_k;
  logic snoop_j;
  logic snoop_k;
  logic free_hit;

  // A producer finishing in the same cycle as the issue would otherwise be missed.
  assign bypass_j = cdb_valid && (issue_qj != NONE) && (cdb_tag == issue_qj);
  assign bypass_k = cdb_valid && (issue_qk != NONE) && (cdb_tag == issue_qk);
  assign snoop_j  = cdb_valid && (qj != NONE) && (cdb_tag == qj);
  assign snoop_k  = cdb_valid && (qk != NONE) && (cdb_tag == qk);
  assign free_hit = cdb_valid && (cdb_tag == MY_TAG);

  // The allocator only writes a free entry, so issue never collides with
  // snoop/free/dispatch on the same entry.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      busy       <= 1'b0;
      dispatched <= 1'b0;
      op         <= ALUAdd;
      vj         <= '0;
      vk         <= '0;
      qj         <= NONE;
      qk         <= NONE;
    end else if (write_en) begin
      busy       <= 1'b1;
      dispatched <= 1'b0;
      op         <= issue_op;
      vj         <= bypass_j ? cdb_data : issue_vj;
      vk         <= bypass_k ? cdb_data : issue_vk;
      qj         <= bypass_j ? NONE : issue_qj;
      qk         <= bypass_k ? NONE : issue_qk;
    end else if (busy) begin
      if (snoop_j) begin
        vj <= cdb_data;
        qj <= NONE;
      end
      if (snoop_k) begin
        vk <= cdb_data;
        qk <= NONE;
      end
      if (free_hit) begin
        busy       <= 1'b0;
        dispatched <= 1'b0;
      end else if (dispatch_set) begin
        dispatched <= 1'b1;
      end
    end
  end

  // Registered state only: a CDB wake-up becomes dispatchable next cycle.
  assign ready = busy && !dispatched && (qj == NONE) && (qk == NONE);

endmodule

// File: rtl/pmf_rs.sv
// pmf_rs: reservation station for the add/sub functional unit.
// It allocates the lowest free entry on issue, and each entry snoops the CDB.
// One ready entry is dispatched per cycle into the registered alu_* outputs.
// An entry stays busy until its own tag is broadcast on the CDB.
// Build option: define PMF_RS_AGE_EN to dispatch the oldest ready entry
// (per-entry saturating age counters); otherwise the lowest-index ready entry
// is dispatched.
// Ports:
//   clk, nRST                    clock, async active-low reset
//   issue_valid/ready/op/vj/vk/qj/qk, issue_tag   issue interface
//   cdb_valid/tag/data           common data bus snoop
//   alu_ready                    ALU can accept an operation
//   alu_en/op/data1/data2/tag    registered dispatch to the ALU
module pmf_rs
  import pmf_rs_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TAG_W   = TAG_W_DEF,
  parameter int ENTRIES = 3,
  parameter int RS_BASE = 1
) (
  input  logic              clk,
  input  logic              nRST,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  alu_op_t           issue_op,
  input  logic [DATA_W-1:0] issue_vj,
  input  logic [DATA_W-1:0] issue_vk,
  input  logic [TAG_W-1:0]  issue_qj,
  input  logic [TAG_W-1:0]  issue_qk,
  output logic [TAG_W-1:0]  issue_tag,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  input  logic              alu_ready,
  output logic              alu_en,
  output alu_op_t           alu_op,
  output logic [DATA_W-1:0] alu_data1,
  output logic [DATA_W-1:0] alu_data2,
  output logic [TAG_W-1:0]  alu_tag
);

  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  logic [ENTRIES-1:0] busy;
  logic [ENTRIES-1:0] ready;
  logic [ENTRIES-1:0] write_en;
  logic [ENTRIES-1:0] dispatch_set;
  alu_op_t            ent_op [ENTRIES];
  logic [DATA_W-1:0]  ent_vj [ENTRIES];
  logic [DATA_W-1:0]  ent_vk [ENTRIES];

  logic [IDX_W-1:0] alloc_idx;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_valid;
  logic             do_issue;
  logic             do_dispatch;

  for (genvar g = 0; g < ENTRIES; g++) begin : g_entry
    pmf_rs_entry #(
      .DATA_W (DATA_W),
      .TAG_W  (TAG_W),
      .MY_TAG (TAG_W'(RS_BASE + g))
    ) u_entry (
      .clk          (clk),
      .nRST         (nRST),
      .write_en     (write_en[g]),
      .issue_op     (issue_op),
      .issue_vj     (issue_vj),
      .issue_vk     (issue_vk),
      .issue_qj     (issue_qj),
      .issue_qk     (issue_qk),
      .cdb_valid    (cdb_valid),
      .cdb_tag      (cdb_tag),
      .cdb_data     (cdb_data),
      .dispatch_set (dispatch_set[g]),
      .busy         (busy[g]),
      .ready        (ready[g]),
      .op           (ent_op[g]),
      .vj           (ent_vj[g]),
      .vk           (ent_vk[g])
    );
  end

  // Busy bits are registered, so an entry freed this cycle is not yet free here.
  assign issue_ready = ~&busy;
  assign do_issue    = issue_valid && issue_ready;
  assign do_dispatch = alu_ready && sel_valid;

  // The loop scans downward so that the lowest-index free entry wins.
  always_comb begin
    alloc_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!busy[i]) alloc_idx = IDX_W'(i);
    end
  end

  assign issue_tag = issue_ready ? (TAG_W'(RS_BASE) + TAG_W'(alloc_idx)) : TAG_W'(NO_TAG);

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      write_en[i]     = do_issue && (alloc_idx == IDX_W'(i));
      dispatch_set[i] = do_dispatch && (sel_idx == IDX_W'(i));
    end
  end

`ifdef PMF_RS_AGE_EN
  localparam logic [IDX_W-1:0] AGE_MAX = IDX_W'(ENTRIES - 1);

  logic [IDX_W-1:0] age [ENTRIES];
  logic [IDX_W-1:0] best_age;

  // A new entry starts at age 0, and every other busy entry ages by one on
  // each issue. The counter saturates, so a larger value always means older.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < ENTRIES; i++) age[i] <= '0;
    end else if (do_issue) begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (write_en[i])
          age[i] <= '0;
        else if (busy[i] && (age[i] != AGE_MAX))
          age[i] <= age[i] + 1'b1;
      end
    end
  end

  // A strict greater-than compare leaves ties with the lowest index.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    best_age  = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (ready[i] && (!sel_valid || (age[i] > best_age))) begin
        sel_valid = 1'b1;
        sel_idx   = IDX_W'(i);
        best_age  = age[i];
      end
    end
  end
`else
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (ready[i]) begin
        sel_valid = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end
`endif

  // alu_en is a one-cycle pulse. The other alu_* outputs hold between dispatches.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      alu_en    <= 1'b0;
      alu_op    <= ALUAdd;
      alu_data1 <= '0;
      alu_data2 <= '0;
      alu_tag   <= TAG_W'(NO_TAG);
    end else begin
      alu_en <= do_dispatch;
      if (do_dispatch) begin
        alu_op    <= ent_op[sel_idx];
        alu_data1 <= ent_vj[sel_idx];
        alu_data2 <= ent_vk[sel_idx];
        alu_tag   <= TAG_W'(RS_BASE) + TAG_W'(sel_idx);
      end
    end
  end

endmodule

// File: tb/tb_pmf_rs.sv
// tb_pmf_rs: self-checking bench for pmf_rs (default parameters).
// Expected dispatches are queued when the stimulus that determines them is
// driven. A negedge monitor pops and compares them on every alu_en pulse.
// Scenario tasks check status outputs and dispatch timing inline.
module tb_pmf_rs;
  import pmf_rs_pkg::*;

  logic        clk = 1'b0;
  logic        nRST;
  logic        issue_valid;
  logic        issue_ready;
  alu_op_t     issue_op;
  logic [31:0] issue_vj, issue_vk;
  logic [2:0]  issue_qj, issue_qk;
  logic [2:0]  issue_tag;
  logic        cdb_valid;
  logic [2:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        alu_ready;
  logic        alu_en;
  alu_op_t     alu_op;
  logic [31:0] alu_data1, alu_data2;
  logic [2:0]  alu_tag;

  typedef struct {
    alu_op_t     op;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [2:0]  tag;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   compared   = 0;
  int   mismatched = 0;

  pmf_rs dut (
    .clk         (clk),
    .nRST        (nRST),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .issue_op    (issue_op),
    .issue_vj    (issue_vj),
    .issue_vk    (issue_vk),
    .issue_qj    (issue_qj),
    .issue_qk    (issue_qk),
    .issue_tag   (issue_tag),
    .cdb_valid   (cdb_valid),
    .cdb_tag     (cdb_tag),
    .cdb_data    (cdb_data),
    .alu_ready   (alu_ready),
    .alu_en      (alu_en),
    .alu_op      (alu_op),
    .alu_data1   (alu_data1),
    .alu_data2   (alu_data2),
    .alu_tag     (alu_tag)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "[TB] watchdog");
  end

  // The scoreboard monitor compares every dispatch against the oldest queued expectation.
  always @(negedge clk) begin
    if (nRST && alu_en) begin
      compared++;
      if (sb.size() == 0) begin
        mismatched++;
        $display("[TB] FAIL unexpected_dispatch: alu_en=1 tag=%0d, required no dispatch", alu_tag);
      end else begin
        e = sb.pop_front();
        if (alu_op !== e.op || alu_data1 !== e.d1 || alu_data2 !== e.d2 || alu_tag !== e.tag) begin
          mismatched++;
          $display("[TB] FAIL dispatch: got op=%0d d1=%h d2=%h tag=%0d, required op=%0d d1=%h d2=%h tag=%0d",
                   alu_op, alu_data1, alu_data2, alu_tag, e.op, e.d1, e.d2, e.tag);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_issue(input alu_op_t op, input logic [31:0] vj, input logic [31:0] vk,
                             input logic [2:0] qj, input logic [2:0] qk);
    issue_valid = 1'b1;
    issue_op    = op;
    issue_vj    = vj;
    issue_vk    = vk;
    issue_qj    = qj;
    issue_qk    = qk;
  endtask

  task automatic drive_cdb(input logic [2:0] tag, input logic [31:0] data);
    cdb_valid = 1'b1;
    cdb_tag   = tag;
    cdb_data  = data;
  endtask

  task automatic free_tag(input logic [2:0] tag);
    drive_cdb(tag, 32'h0);
    step();
    cdb_valid = 1'b0;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    #12;
    compared++;
    if (alu_en !== 1'b0 || alu_op !== ALUAdd || alu_data1 !== 32'h0 || alu_data2 !== 32'h0 || alu_tag !== 3'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_outputs: got en=%0b op=%0d d1=%h d2=%h tag=%0d, required 0/ADD/0/0/0",
               alu_en, alu_op, alu_data1, alu_data2, alu_tag);
    end
    @(negedge clk);
    nRST = 1'b1;
    step();
    compared++;
    if (issue_ready !== 1'b1 || issue_tag !== 3'd1) begin
      mismatched++;
      $display("[TB] FAIL reset_release: got issue_ready=%0b issue_tag=%0d, required 1/1", issue_ready, issue_tag);
    end
  endtask

  task automatic test_basic_add();
    drive_issue(ALUAdd, 32'd5, 32'd7, 3'd0, 3'd0);
    #1;
    compared++;
    if (issue_tag !== 3'd1) begin
      mismatched++;
      $display("[TB] FAIL add_issue_tag: got %0d, required 1", issue_tag);
    end
    sb.push_back('{ALUAdd, 32'd5, 32'd7, 3'd1});
    step();
    issue_valid = 1'b0;
    compared++;
    if (alu_en !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL add_early_dispatch: got alu_en=%0b one edge after issue, required 0", alu_en);
    end
    step();
    compared++;
    if (alu_en !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL add_latency: got alu_en=%0b two edges after issue, required 1", alu_en);
    end
    free_tag(3'd1);
  endtask

  task automatic test_cdb_wakeup();
    drive_issue(ALUSub, 32'h0, 32'd4, 3'd3, 3'd0);
    step();
    issue_valid = 1'b0;
    step();
    step();
    compared++;
    if (alu_en !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL wake_wait: got alu_en=%0b while operand pending, required 0", alu_en);
    end
    drive_cdb(3'd3, 32'h10);
    sb.push_back('{ALUSub, 32'h10, 32'd4, 3'd1});
    step();
    cdb_valid = 1'b0;
    compared++;
    if (alu_en !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL wake_same_cycle: got alu_en=%0b at capture edge, required 0", alu_en);
    end
    step();
    compared++;
    if (alu_en !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL wake_dispatch: got alu_en=%0b edge after capture, required 1", alu_en);
    end
    free_tag(3'd1);
  endtask

  task automatic test_issue_bypass();
    drive_issue(ALUAdd, 32'd1, 32'h0, 3'd0, 3'd2);
    drive_cdb(3'd2, 32'd9);
    sb.push_back('{ALUAdd, 32'd1, 32'd9, 3'd1});
    step();
    issue_valid = 1'b0;
    cdb_valid   = 1'b0;
    step();
    compared++;
    if (alu_en !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL bypass_dispatch: got alu_en=%0b, required 1", alu_en);
    end
    free_tag(3'd1);
  endtask

  task automatic test_full();
    for (int i = 1; i <= 3; i++) begin
      drive_issue(ALUAdd, 32'(i), 32'(i), 3'd7, 3'd0);
      #1;
      compared++;
      if (issue_tag !== 3'(i)) begin
        mismatched++;
        $display("[TB] FAIL fill_tag: got %0d, required %0d", issue_tag, i);
      end
      step();
    end
    drive_issue(ALUAdd, 32'hAA, 32'hBB, 3'd0, 3'd0);
    #1;
    compared++;
    if (issue_ready !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL full_ready: got issue_ready=%0b, required 0", issue_ready);
    end
    step();
    issue_valid = 1'b0;
    drive_cdb(3'd2, 32'h0);
    #1;
    compared++;
    if (issue_ready !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL free_same_cycle: got issue_ready=%0b, required 0", issue_ready);
    end
    step();
    cdb_valid = 1'b0;
    compared++;
    if (issue_ready !== 1'b1 || issue_tag !== 3'd2) begin
      mismatched++;
      $display("[TB] FAIL free_next_cycle: got ready=%0b tag=%0d, required 1/2", issue_ready, issue_tag);
    end
    drive_issue(ALUAdd, 32'h20, 32'h30, 3'd0, 3'd0);
    sb.push_back('{ALUAdd, 32'h20, 32'h30, 3'd2});
    step();
    issue_valid = 1'b0;
    step();
    compared++;
    if (alu_en !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL refill_dispatch: got alu_en=%0b, required 1", alu_en);
    end
    free_tag(3'd1);
    free_tag(3'd2);
    free_tag(3'd3);
  endtask

  task automatic test_back_to_back();
    alu_ready = 1'b0;
    drive_issue(ALUAdd, 32'h0, 32'h0, 3'd7, 3'd0);
    step();
    drive_issue(ALUAdd, 32'h100, 32'h1, 3'd0, 3'd0);
    #1;
    compared++;
    if (issue_tag !== 3'd2) begin
      mismatched++;
      $display("[TB] FAIL b2b_tag_a: got %0d, required 2", issue_tag);
    end
    step();
    issue_valid = 1'b0;
    free_tag(3'd1);
    drive_issue(ALUSub, 32'h200, 32'h2, 3'd0, 3'd0);
    #1;
    compared++;
    if (issue_tag !== 3'd1) begin
      mismatched++;
      $display("[TB] FAIL b2b_tag_b: got %0d, required 1", issue_tag);
    end
    step();
    issue_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      compared++;
      if (alu_en !== 1'b0 || alu_data1 !== 32'h20) begin
        mismatched++;
        $display("[TB] FAIL stall: got alu_en=%0b d1=%h, required 0/00000020 (held)", alu_en, alu_data1);
      end
      step();
    end
`ifdef PMF_RS_AGE_EN
    sb.push_back('{ALUAdd, 32'h100, 32'h1, 3'd2});
    sb.push_back('{ALUSub, 32'h200, 32'h2, 3'd1});
`else
    sb.push_back('{ALUSub, 32'h200, 32'h2, 3'd1});
    sb.push_back('{ALUAdd, 32'h100, 32'h1, 3'd2});
`endif
    alu_ready = 1'b1;
    step();
    compared++;
    if (alu_en !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL b2b_first: got alu_en=%0b, required 1", alu_en);
    end
    step();
    compared++;
    if (alu_en !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL b2b_second: got alu_en=%0b, required 1", alu_en);
    end
    step();
    compared++;
    if (alu_en !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL b2b_idle: got alu_en=%0b, required 0", alu_en);
    end
    free_tag(3'd1);
    free_tag(3'd2);
  endtask

  task automatic test_reset_mid();
    drive_issue(ALUAdd, 32'd3, 32'd4, 3'd0, 3'd0);
    sb.push_back('{ALUAdd, 32'd3, 32'd4, 3'd1});
    step();
    drive_issue(ALUSub, 32'h0, 32'h0, 3'd7, 3'd0);
    step();
    issue_valid = 1'b0;
    compared++;
    if (alu_en !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL mid_dispatch: got alu_en=%0b before reset, required 1", alu_en);
    end
    @(negedge clk);
    #1;
    nRST = 1'b0;
    #1;
    compared++;
    if (alu_en !== 1'b0 || alu_op !== ALUAdd || alu_data1 !== 32'h0 || alu_data2 !== 32'h0 ||
        alu_tag !== 3'd0 || issue_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL mid_reset: got en=%0b op=%0d d1=%h d2=%h tag=%0d rdy=%0b, required 0/ADD/0/0/0/1",
               alu_en, alu_op, alu_data1, alu_data2, alu_tag, issue_ready);
    end
    @(negedge clk);
    nRST = 1'b1;
    #1;
    compared++;
    if (issue_ready !== 1'b1 || issue_tag !== 3'd1) begin
      mismatched++;
      $display("[TB] FAIL mid_release: got ready=%0b tag=%0d, required 1/1", issue_ready, issue_tag);
    end
    step();
    step();
    compared++;
    if (alu_en !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL mid_discard: got alu_en=%0b after reset, required 0", alu_en);
    end
  endtask

  initial begin
    nRST        = 1'b0;
    issue_valid = 1'b0;
    issue_op    = ALUAdd;
    issue_vj    = '0;
    issue_vk    = '0;
    issue_qj    = '0;
    issue_qk    = '0;
    cdb_valid   = 1'b0;
    cdb_tag     = '0;
    cdb_data    = '0;
    alu_ready   = 1'b1;

    test_reset();
    test_basic_add();
    test_cdb_wakeup();
    test_issue_bypass();
    test_full();
    test_back_to_back();
    test_reset_mid();

    step();
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending dispatches, required 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
